// File: rtl/fetch_unit.sv
// Instruction fetch unit: two-stage ROM reads for a 1/2-byte instruction stream, presented to the decoder.
// Build option FETCH_ILLEGAL_TRAP_EN: an unknown opcode locks the FSM in TRAP until reset.
module fetch_unit #(
    parameter logic [7:0] RESET_VECTOR = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic [7:0] pc,
    output logic       illegal
);

    // state    | meaning
    // OP_ADDR  | opcode address on rom_addr
    // OP_DATA  | opcode byte on rom_data, latch it
    // OPR_ADDR | operand address on rom_addr
    // OPR_DATA | operand byte on rom_data, latch it
    // HOLD     | instruction presented until accepted
    // TRAP     | illegal opcode seen, parked until reset (trap build only)
    typedef enum logic [2:0] {
        OP_ADDR,
        OP_DATA,
        OPR_ADDR,
        OPR_DATA,
        HOLD
`ifdef FETCH_ILLEGAL_TRAP_EN
        ,
        TRAP
`endif
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [6:0] pc_q;
    logic       two_byte;
    logic       one_byte;
    logic       bad_op;
    logic       unused_bits;

    assign unused_bits = branch_target[7];

    assign rom_addr    = {1'b0, pc_q};
    assign pc          = {1'b0, pc_q};
    assign instr_valid = (state == HOLD);

    always_comb begin
        two_byte = ((rom_data >= 8'h20) && (rom_data <= 8'h28)) ||
                   ((rom_data >= 8'h86) && (rom_data <= 8'h89)) ||
                   (rom_data == 8'h96) || (rom_data == 8'h97);
        one_byte = (rom_data >= 8'h42) && (rom_data <= 8'h4C);
        bad_op   = !two_byte && !one_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OP_ADDR;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            OP_ADDR:  state_n = OP_DATA;
            OP_DATA: begin
                if (two_byte) begin
                    state_n = OPR_ADDR;
                end else begin
                    state_n = HOLD;
                end
`ifdef FETCH_ILLEGAL_TRAP_EN
                if (bad_op) begin
                    state_n = TRAP;
                end
`endif
            end
            OPR_ADDR: state_n = OPR_DATA;
            OPR_DATA: state_n = HOLD;
            HOLD: begin
                if (instr_ready) begin
                    state_n = OP_ADDR;
                end
            end
`ifdef FETCH_ILLEGAL_TRAP_EN
            TRAP:     state_n = TRAP;
`endif
            default:  state_n = OP_ADDR;
        endcase
    end

    // Illegal opcodes fall through as one-byte instructions unless trapping is built in.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR[6:0];
            opcode  <= 8'h00;
            operand <= 8'h00;
            illegal <= 1'b0;
        end else begin
            case (state)
                OP_DATA: begin
                    opcode <= rom_data;
                    pc_q   <= pc_q + 7'd1;
                    if (!two_byte) begin
                        operand <= 8'h00;
                    end
                    if (bad_op) begin
                        illegal <= 1'b1;
                    end
                end
                OPR_DATA: begin
                    operand <= rom_data;
                    pc_q    <= pc_q + 7'd1;
                end
                HOLD: begin
                    if (instr_ready && branch_taken) begin
                        pc_q <= branch_target[6:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
